// File: rtl/snake_gfx_pkg.sv
// rtl/snake_gfx_pkg.sv - shared glyph geometry, colour width and blink state encoding
package snake_gfx_pkg;

    localparam int GLYPH_W    = 20;
    localparam int GLYPH_H    = 20;
    localparam int GLYPH_BITS = GLYPH_W * GLYPH_H;
    localparam int LETTER_W   = 4;
    localparam int RGB_W      = 12;
    localparam int COORD_W    = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_HIDE = 2'd2
    } blink_state_t;

    // Bitmaps are stored MSB first: row 0 / col 0 lives at bit GLYPH_BITS-1.
    function automatic logic [8:0] glyph_bit_index(input logic [4:0] row, input logic [4:0] col);
        return 9'(GLYPH_BITS - 1) - (9'(row) * 9'(GLYPH_W) + 9'(col));
    endfunction

endpackage

// File: rtl/blink_fsm.sv
// rtl/blink_fsm.sv - frame tick detection and SHOW/HIDE blink state machine
module blink_fsm
    import snake_gfx_pkg::*;
#(
    parameter int BLINK_FRAMES = 30
) (
    input  logic               clock_25,
    input  logic               reset_n,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    input  logic               game_over,
    output logic               show_en
);

    localparam int CW = $clog2(BLINK_FRAMES + 1);
    localparam logic [CW-1:0] LAST_TICK = CW'(BLINK_FRAMES - 1);

    blink_state_t  state;
    logic [CW-1:0] frame_cnt;
    logic          at_origin;
    logic          at_origin_q;
    logic          frame_tick;

    // Edge-detect the origin so a scan parked on (0,0) still counts as one frame.
    assign at_origin  = (pixel_x == '0) && (pixel_y == '0);
    assign frame_tick = at_origin & ~at_origin_q;

    always_ff @(posedge clock_25) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            frame_cnt   <= '0;
            show_en     <= 1'b0;
            at_origin_q <= 1'b0;
        end else begin
            at_origin_q <= at_origin;
            if (!game_over) begin
                state     <= ST_IDLE;
                frame_cnt <= '0;
                show_en   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state     <= ST_SHOW;
                        frame_cnt <= '0;
                        show_en   <= 1'b1;
                    end
                    ST_SHOW: begin
                        if (frame_tick) begin
                            if (frame_cnt == LAST_TICK) begin
                                state     <= ST_HIDE;
                                frame_cnt <= '0;
                                show_en   <= 1'b0;
                            end else begin
                                frame_cnt <= frame_cnt + 1'b1;
                            end
                        end
                    end
                    ST_HIDE: begin
                        if (frame_tick) begin
                            if (frame_cnt == LAST_TICK) begin
                                state     <= ST_SHOW;
                                frame_cnt <= '0;
                                show_en   <= 1'b1;
                            end else begin
                                frame_cnt <= frame_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        frame_cnt <= '0;
                        show_en   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/game_over_renderer.sv
// rtl/game_over_renderer.sv - scans the GAME OVER text box, fetches glyph bits and emits pixel colour
module game_over_renderer
    import snake_gfx_pkg::*;
#(
    parameter int               ORIGIN_X     = 140,
    parameter int               ORIGIN_Y     = 200,
    parameter int               SCALE_LOG2   = 1,
    parameter int               NUM_LETTERS  = 9,
    parameter int               BLINK_FRAMES = 30,
    parameter logic [RGB_W-1:0] TEXT_RGB     = 12'h0F0
) (
    input  logic                  clock_25,
    input  logic                  reset_n,
    input  logic [COORD_W-1:0]    pixel_x,
    input  logic [COORD_W-1:0]    pixel_y,
    input  logic                  video_on,
    input  logic                  game_over,
    input  logic [GLYPH_BITS-1:0] letter_count_over,
    output logic [LETTER_W-1:0]   selected_letter_over,
    output logic                  pixel_on,
    output logic [RGB_W-1:0]      text_rgb,
    output logic                  video_on_d
);

    localparam int CELL  = 1 << SCALE_LOG2;
    localparam int BOX_W = NUM_LETTERS * GLYPH_W * CELL;
    localparam int BOX_H = GLYPH_H * CELL;
    localparam int SUB_W = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;

    localparam logic [SUB_W-1:0]    SUB_LAST    = SUB_W'(CELL - 1);
    localparam logic [4:0]          COL_LAST    = 5'(GLYPH_W - 1);
    localparam logic [LETTER_W-1:0] LETTER_LAST = LETTER_W'(NUM_LETTERS - 1);

    logic                show_en;
    logic                in_box;
    logic                at_start;
    logic [COORD_W-1:0]  y_off;
    logic [4:0]          row_cur;

    logic [SUB_W-1:0]    sub_q, sub_cur, sub_nxt;
    logic [4:0]          col_q, col_cur, col_nxt;
    logic [LETTER_W-1:0] letter_q, letter_cur, letter_nxt;

    logic [4:0]          row_s0, col_s0, row_s1, col_s1;
    logic                in_box_s0, in_box_s1;
    logic                vid_s0, vid_s1;
    logic                glyph_bit;
    logic                lit;

    blink_fsm #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink_fsm (
        .clock_25 (clock_25),
        .reset_n  (reset_n),
        .pixel_x  (pixel_x),
        .pixel_y  (pixel_y),
        .game_over(game_over),
        .show_en  (show_en)
    );

    assign in_box = ({1'b0, pixel_x} >= 11'(ORIGIN_X)) && ({1'b0, pixel_x} < 11'(ORIGIN_X + BOX_W))
                 && ({1'b0, pixel_y} >= 11'(ORIGIN_Y)) && ({1'b0, pixel_y} < 11'(ORIGIN_Y + BOX_H));
    assign at_start = (pixel_x == COORD_W'(ORIGIN_X));
    assign y_off    = pixel_y - COORD_W'(ORIGIN_Y);
    assign row_cur  = 5'(y_off >> SCALE_LOG2);

    // The counters hold the position of the current pixel; the left edge forces zero
    // on the same cycle so column 0 is never stale from the previous line.
    always_comb begin
        sub_cur    = at_start ? '0 : sub_q;
        col_cur    = at_start ? '0 : col_q;
        letter_cur = at_start ? '0 : letter_q;
        sub_nxt    = sub_cur;
        col_nxt    = col_cur;
        letter_nxt = letter_cur;
        if (in_box) begin
            if (sub_cur == SUB_LAST) begin
                sub_nxt = '0;
                if (col_cur == COL_LAST) begin
                    col_nxt    = '0;
                    letter_nxt = (letter_cur == LETTER_LAST) ? letter_cur : letter_cur + 1'b1;
                end else begin
                    col_nxt = col_cur + 1'b1;
                end
            end else begin
                sub_nxt = sub_cur + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_25) begin
        if (!reset_n) begin
            sub_q    <= '0;
            col_q    <= '0;
            letter_q <= '0;
        end else begin
            sub_q    <= sub_nxt;
            col_q    <= col_nxt;
            letter_q <= letter_nxt;
        end
    end

    // Stage 0 drives the ROM address; stage 1 waits out the ROM's registered read.
    always_ff @(posedge clock_25) begin
        if (!reset_n) begin
            selected_letter_over <= '0;
            row_s0               <= '0;
            col_s0               <= '0;
            in_box_s0            <= 1'b0;
            vid_s0               <= 1'b0;
            row_s1               <= '0;
            col_s1               <= '0;
            in_box_s1            <= 1'b0;
            vid_s1               <= 1'b0;
        end else begin
            if (in_box) begin
                selected_letter_over <= letter_cur;
            end
            row_s0    <= in_box ? row_cur : '0;
            col_s0    <= in_box ? col_cur : '0;
            in_box_s0 <= in_box;
            vid_s0    <= video_on;
            row_s1    <= row_s0;
            col_s1    <= col_s0;
            in_box_s1 <= in_box_s0;
            vid_s1    <= vid_s0;
        end
    end

    assign glyph_bit = letter_count_over[glyph_bit_index(row_s1, col_s1)];
    assign lit       = glyph_bit & in_box_s1 & vid_s1 & show_en;

    always_ff @(posedge clock_25) begin
        if (!reset_n) begin
            pixel_on   <= 1'b0;
            text_rgb   <= '0;
            video_on_d <= 1'b0;
        end else begin
            pixel_on   <= lit;
            text_rgb   <= lit ? TEXT_RGB : '0;
            video_on_d <= vid_s1;
        end
    end

endmodule

// File: tb/tb_game_over_renderer.sv
// tb/tb_game_over_renderer.sv - directed self-checking bench for game_over_renderer
module tb_game_over_renderer;

    logic         clock_25 = 1'b0;
    logic         reset_n;
    logic [9:0]   pixel_x;
    logic [9:0]   pixel_y;
    logic         video_on;
    logic         game_over;
    logic [399:0] letter_count_over;
    logic [3:0]   selected_letter_over;
    logic         pixel_on;
    logic [11:0]  text_rgb;
    logic         video_on_d;

    int vectors     = 0;
    int miscompares = 0;
    int rom_mode    = 1;

    logic [3:0]  sel_h [0:1023];
    logic        pon_h [0:1023];
    logic [11:0] rgb_h [0:1023];
    logic        vid_h [0:1023];

    game_over_renderer #(
        .BLINK_FRAMES(2)
    ) dut (
        .clock_25            (clock_25),
        .reset_n             (reset_n),
        .pixel_x             (pixel_x),
        .pixel_y             (pixel_y),
        .video_on            (video_on),
        .game_over           (game_over),
        .letter_count_over   (letter_count_over),
        .selected_letter_over(selected_letter_over),
        .pixel_on            (pixel_on),
        .text_rgb            (text_rgb),
        .video_on_d          (video_on_d)
    );

    always #20 clock_25 = ~clock_25;

    // Stub glyph ROM with a one-clock registered read.
    function automatic logic [399:0] rom_fn(input logic [3:0] l, input int mode);
        logic [399:0] b;
        b = '0;
        case (mode)
            0: begin
                b[399:396] = ~l;
                b[395:392] = l;
            end
            1: b = '1;
            default: b[0] = (l == 4'd8);
        endcase
        return b;
    endfunction

    always @(posedge clock_25) letter_count_over <= rom_fn(selected_letter_over, rom_mode);

    task automatic step();
        @(posedge clock_25);
        #1;
    endtask

    task automatic park();
        pixel_x  = 10'd600;
        pixel_y  = 10'd600;
        video_on = 1'b0;
    endtask

    task automatic scan(input int y, input int x0, input int x1, input logic vid);
        for (int x = x0; x <= x1 + 2; x++) begin
            pixel_x  = 10'(x);
            pixel_y  = 10'(y);
            video_on = vid;
            step();
            sel_h[x] = selected_letter_over;
            if (x - 2 >= x0) begin
                pon_h[x-2] = pixel_on;
                rgb_h[x-2] = text_rgb;
                vid_h[x-2] = video_on_d;
            end
        end
        park();
        step();
    endtask

    task automatic frame(input bit do_tick, input logic exp, input string tag);
        if (do_tick) begin
            pixel_x = 10'd0;
            pixel_y = 10'd0;
            step();
            park();
            step();
        end
        scan(200, 139, 141, 1'b1);
        vectors++;
        if (pon_h[140] !== exp) begin
            miscompares++;
            $display("FAIL %s pixel_on got %b want %b", tag, pon_h[140], exp);
        end
    endtask

    task automatic abort_with_tick();
        pixel_x   = 10'd0;
        pixel_y   = 10'd0;
        game_over = 1'b0;
        step();
        game_over = 1'b1;
        park();
        step();
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        game_over = 1'b1;
        rom_mode  = 1;
        video_on  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pixel_x = 10'(140 + i);
            pixel_y = 10'd200;
            step();
            vectors += 4;
            if (pixel_on !== 1'b0) begin miscompares++; $display("FAIL reset_pixel_on got %b want 0", pixel_on); end
            if (text_rgb !== 12'h000) begin miscompares++; $display("FAIL reset_rgb got %h want 000", text_rgb); end
            if (selected_letter_over !== 4'd0) begin miscompares++; $display("FAIL reset_sel got %0d want 0", selected_letter_over); end
            if (video_on_d !== 1'b0) begin miscompares++; $display("FAIL reset_vid got %b want 0", video_on_d); end
        end
        reset_n   = 1'b1;
        game_over = 1'b0;
        park();
        step();
        step();
        scan(200, 139, 142, 1'b1);
        vectors += 2;
        if (pon_h[140] !== 1'b0) begin miscompares++; $display("FAIL idle_pixel_on got %b want 0", pon_h[140]); end
        if (vid_h[140] !== 1'b1) begin miscompares++; $display("FAIL idle_vid got %b want 1", vid_h[140]); end
        game_over = 1'b1;
        step();
        scan(200, 139, 142, 1'b1);
        vectors += 2;
        if (pon_h[140] !== 1'b1) begin miscompares++; $display("FAIL show_pixel_on got %b want 1", pon_h[140]); end
        if (rgb_h[140] !== 12'h0F0) begin miscompares++; $display("FAIL show_rgb got %h want 0f0", rgb_h[140]); end
    endtask

    task automatic test_letter_map();
        rom_mode = 0;
        step();
        scan(200, 139, 501, 1'b1);
        for (int x = 140; x < 180; x++) begin
            vectors++;
            if (sel_h[x] !== 4'd0) begin miscompares++; $display("FAIL map_sel_x%0d got %0d want 0", x, sel_h[x]); end
        end
        vectors += 12;
        if (sel_h[180] !== 4'd1) begin miscompares++; $display("FAIL map_sel_x180 got %0d want 1", sel_h[180]); end
        if (sel_h[499] !== 4'd8) begin miscompares++; $display("FAIL map_sel_x499 got %0d want 8", sel_h[499]); end
        if (sel_h[500] !== 4'd8) begin miscompares++; $display("FAIL map_sel_x500 got %0d want 8", sel_h[500]); end
        if (pon_h[140] !== 1'b1) begin miscompares++; $display("FAIL map_pon_x140 got %b want 1", pon_h[140]); end
        if (pon_h[141] !== 1'b1) begin miscompares++; $display("FAIL map_pon_x141 got %b want 1", pon_h[141]); end
        if (pon_h[148] !== 1'b0) begin miscompares++; $display("FAIL map_pon_x148 got %b want 0", pon_h[148]); end
        if (rgb_h[148] !== 12'h000) begin miscompares++; $display("FAIL map_rgb_x148 got %h want 000", rgb_h[148]); end
        if (pon_h[180] !== 1'b1) begin miscompares++; $display("FAIL map_pon_x180 got %b want 1", pon_h[180]); end
        if (pon_h[186] !== 1'b0) begin miscompares++; $display("FAIL map_pon_x186 got %b want 0", pon_h[186]); end
        if (pon_h[194] !== 1'b1) begin miscompares++; $display("FAIL map_pon_x194 got %b want 1", pon_h[194]); end
        if (pon_h[460] !== 1'b0) begin miscompares++; $display("FAIL map_pon_x460 got %b want 0", pon_h[460]); end
        if (pon_h[462] !== 1'b1) begin miscompares++; $display("FAIL map_pon_x462 got %b want 1", pon_h[462]); end
    endtask

    task automatic test_boundaries();
        rom_mode = 1;
        step();
        scan(200, 138, 501, 1'b1);
        vectors += 5;
        if (pon_h[139] !== 1'b0) begin miscompares++; $display("FAIL bnd_x139 got %b want 0", pon_h[139]); end
        if (pon_h[140] !== 1'b1) begin miscompares++; $display("FAIL bnd_x140 got %b want 1", pon_h[140]); end
        if (pon_h[499] !== 1'b1) begin miscompares++; $display("FAIL bnd_x499 got %b want 1", pon_h[499]); end
        if (pon_h[500] !== 1'b0) begin miscompares++; $display("FAIL bnd_x500 got %b want 0", pon_h[500]); end
        if (rgb_h[500] !== 12'h000) begin miscompares++; $display("FAIL bnd_rgb_x500 got %h want 000", rgb_h[500]); end
        scan(239, 139, 141, 1'b1);
        vectors++;
        if (pon_h[140] !== 1'b1) begin miscompares++; $display("FAIL bnd_y239 got %b want 1", pon_h[140]); end
        scan(240, 139, 141, 1'b1);
        vectors++;
        if (pon_h[140] !== 1'b0) begin miscompares++; $display("FAIL bnd_y240 got %b want 0", pon_h[140]); end
        scan(199, 139, 141, 1'b1);
        vectors++;
        if (pon_h[140] !== 1'b0) begin miscompares++; $display("FAIL bnd_y199 got %b want 0", pon_h[140]); end
        scan(200, 139, 141, 1'b0);
        vectors += 2;
        if (pon_h[140] !== 1'b0) begin miscompares++; $display("FAIL bnd_video_off got %b want 0", pon_h[140]); end
        if (vid_h[140] !== 1'b0) begin miscompares++; $display("FAIL bnd_vid_d got %b want 0", vid_h[140]); end
    endtask

    task automatic test_bottom_right();
        rom_mode = 2;
        step();
        scan(238, 138, 501, 1'b1);
        vectors += 4;
        if (pon_h[499] !== 1'b1) begin miscompares++; $display("FAIL br_pon_x499 got %b want 1", pon_h[499]); end
        if (rgb_h[499] !== 12'h0F0) begin miscompares++; $display("FAIL br_rgb_x499 got %h want 0f0", rgb_h[499]); end
        if (pon_h[497] !== 1'b0) begin miscompares++; $display("FAIL br_pon_x497 got %b want 0", pon_h[497]); end
        if (pon_h[459] !== 1'b0) begin miscompares++; $display("FAIL br_pon_x459 got %b want 0", pon_h[459]); end
    endtask

    task automatic test_blink();
        rom_mode  = 1;
        game_over = 1'b0;
        park();
        step();
        step();
        game_over = 1'b1;
        step();
        frame(1'b0, 1'b1, "blink_t0");
        frame(1'b1, 1'b1, "blink_t1");
        frame(1'b1, 1'b0, "blink_t2");
        frame(1'b1, 1'b0, "blink_t3");
        frame(1'b1, 1'b1, "blink_t4");
        frame(1'b1, 1'b1, "blink_t5");
        frame(1'b1, 1'b0, "blink_t6");
        frame(1'b1, 1'b0, "blink_t7");
    endtask

    task automatic test_abort();
        abort_with_tick();
        frame(1'b0, 1'b1, "abort1_t0");
        frame(1'b1, 1'b1, "abort1_t1");
        frame(1'b1, 1'b0, "abort1_t2");
        abort_with_tick();
        frame(1'b0, 1'b1, "abort2_t0");
        frame(1'b1, 1'b1, "abort2_t1");
        frame(1'b1, 1'b0, "abort2_t2");
    endtask

    initial begin
        pixel_x   = 10'd600;
        pixel_y   = 10'd600;
        video_on  = 1'b0;
        game_over = 1'b0;
        reset_n   = 1'b0;
        test_reset();
        test_letter_map();
        test_boundaries();
        test_bottom_right();
        test_blink();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/game_over_renderer.md
Name: game_over_renderer

Overview:
- Pixel-side reader of the GAME OVER glyph ROM (`game_over`). It sits between the VGA timing generator and the colour mux.
- For each scanned pixel inside the text box, it drives `selected_letter_over` to the ROM and takes the returned 400-bit 20x20 bitmap on `letter_count_over`.
- It extracts the bit for the current pixel and outputs a pixel-on flag plus RGB, pipelined against the scan.
- A frame-counting FSM blinks the text while `game_over` is asserted.

Parameters:
- ORIGIN_X, 140, left pixel column of the text box
- ORIGIN_Y, 200, top pixel row of the text box
- SCALE_LOG2, 1, each bitmap cell is 2^SCALE_LOG2 x 2^SCALE_LOG2 pixels
- NUM_LETTERS, 9, glyph slots drawn, ROM indices 0..NUM_LETTERS-1
- BLINK_FRAMES, 30, frames per SHOW and per HIDE phase
- TEXT_RGB, 12'h0F0, colour of lit pixels (green)

Ports:
- clock_25  in  1  25 MHz pixel clock
- reset_n  in  1  synchronous, active-low reset
- pixel_x  in  10  current scan column; advances by 1 per clock within a line
- pixel_y  in  10  current scan row
- video_on  in  1  active-video flag aligned with pixel_x/pixel_y
- game_over  in  1  level: text display enabled
- letter_count_over  in  400  bitmap from ROM, valid 1 clock after selected_letter_over
- selected_letter_over  out  4  ROM letter index
- pixel_on  out  1  current (delayed) pixel is a lit text cell
- text_rgb  out  12  TEXT_RGB when pixel_on, else 0
- video_on_d  out  1  video_on delayed to align with pixel_on

Behaviour:
- Reset (reset_n low at a clock edge) sets all outputs to 0, the FSM to IDLE, and all counters and pipeline registers to 0. Reset mid-frame takes effect on the next edge; it is not deferred to a frame boundary.
- Box: width NUM_LETTERS*20*2^SCALE_LOG2 pixels, height 20*2^SCALE_LOG2 pixels.
- A pixel is in the box when ORIGIN_X <= x < ORIGIN_X+width and ORIGIN_Y <= y < ORIGIN_Y+height.
- Row cell (0..19): (pixel_y-ORIGIN_Y)>>SCALE_LOG2, computed by shift.
- Column tracking uses counters, not division: sub (0..2^SCALE_LOG2-1), col (0..19), letter (0..NUM_LETTERS-1).
  - All three counters load 0 on a cycle with pixel_x==ORIGIN_X.
  - Otherwise, inside the box, sub increments each clock.
  - sub wrap increments col; col 19->0 increments letter.
  - letter saturates at NUM_LETTERS-1; outside the box the counters hold.
- Pipeline, latency 2 clocks from pixel_x/pixel_y to pixel_on/text_rgb/video_on_d:
  - Stage 0: register selected_letter_over=letter, row, col, in_box, video_on.
  - Stage 1: the ROM returns the bitmap. Delay row/col/in_box/video_on by one stage.
  - Stage 2: bit = letter_count_over[399-(row*20+col)]; row 0 is the top row and col 0 the leftmost, i.e. MSB first.
  - Stage 2 output: pixel_on = bit & in_box_d & video_on_d & (state==SHOW).
- Outside the box, selected_letter_over holds its last value and pixel_on=0.
- Frame tick: one clock pulse when pixel_x==0 && pixel_y==0.
- FSM:
  - IDLE: frame counter 0. game_over=1 -> SHOW.
  - SHOW: count frame ticks. At BLINK_FRAMES ticks -> HIDE, counter cleared.
  - HIDE: same count, then -> SHOW.
  - From any state, game_over=0 -> IDLE on the next clock, counter cleared. This has priority over a simultaneous frame tick.
- Frame counter width: clog2(BLINK_FRAMES+1) bits; it never wraps.

Decomposition:
- Shared package `snake_gfx_pkg`:
  - GLYPH_W=20, GLYPH_H=20, GLYPH_BITS=400
  - letter index width 4
  - FSM state encoding IDLE/SHOW/HIDE
  - colour width 12
- The glyph ROM `game_over` is instantiated at top level, not inside this block.
- One natural sub-module: `blink_fsm` (FSM, frame tick detection, frame counter). It outputs show_en.

Test Plan:
- Reset: hold reset_n=0 for 3 clocks during scan -> pixel_on=0, text_rgb=0, selected_letter_over=0, video_on_d=0. FSM is IDLE on release.
- Letter/bit mapping (SCALE_LOG2=1, stub ROM echoes index into bitmap pattern, game_over=1, state SHOW):
  - Scan y=200, x=140..179 -> selected_letter_over=0.
  - x=180 -> 1.
  - x=500 -> 8.
  - pixel_on for x=140,141 equals bit 399 of the stub glyph, 2 clocks later.
- Boundaries: x=139 and x=500 (box end 140+360) -> pixel_on=0; y=239 inside, y=240 outside. Stub ROM returns all-ones.
- Bottom-right cell: y=238, x=499 with glyph 8 bit 0 set -> pixel_on=1, text_rgb=12'h0F0.
- Blink (BLINK_FRAMES=2, short frames): game_over rises -> SHOW for 2 frame ticks, HIDE for 2 (pixel_on=0 over lit cells), then SHOW again.
- Abort: drop game_over during HIDE, simultaneous with a frame tick -> IDLE next clock, counter 0. Re-raising game_over -> SHOW with a full BLINK_FRAMES count.
